// File: rtl/rs232_tx_arbiter.sv
// rs232_tx_arbiter
//   Two-client byte arbiter in front of a single RS-232 transmitter. Each client
//   owns a DEPTH-entry FIFO. Nonempty FIFOs are served round-robin, one byte per
//   transmitter handshake.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-low reset
//   wr0/din0   client 0 write strobe / byte
//   full0      client 0 FIFO holds DEPTH bytes
//   wr1/din1   client 1 write strobe / byte
//   full1      client 1 FIFO holds DEPTH bytes
//   ovf        sticky per-client drop flags (write while full)
//   fsel_in    requested baud select (1=fast, 0=slow)
//   tx_fsel    baud select presented to the transmitter
//   tx_start   one-cycle send request
//   tx_data    byte to send, valid while tx_start=1
//   tx_rdy     transmitter idle (1) / sending (0)
//   busy       FSM is not idle
//   grant_id   client whose byte is issued or in flight
module rs232_tx_arbiter #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr0,
  input  logic [7:0] din0,
  output logic       full0,
  input  logic       wr1,
  input  logic [7:0] din1,
  output logic       full1,
  output logic [1:0] ovf,
  input  logic       fsel_in,
  output logic       tx_fsel,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_rdy,
  output logic       busy,
  output logic       grant_id
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWaitBusy, StWaitDone} state_e;

  state_e          state_q;
  logic [7:0]      mem0_q [DEPTH];
  logic [7:0]      mem1_q [DEPTH];
  logic [AW-1:0]   wptr0_q, rptr0_q, wptr1_q, rptr1_q;
  logic [CW-1:0]   cnt0_q, cnt1_q;
  logic [1:0]      ovf_q;
  logic [7:0]      data_q;
  logic            grant_q;
  logic            last_q;
  logic            fsel_q;

  logic            ne0, ne1;
  logic            grant_go, gnt_sel;
  logic            push0, push1, pop0, pop1;
  logic [7:0]      head_data;

  always_comb begin
    full0     = (cnt0_q == CW'(DEPTH));
    full1     = (cnt1_q == CW'(DEPTH));
    ne0       = (cnt0_q != '0);
    ne1       = (cnt1_q != '0);
    grant_go  = (state_q == StIdle) && tx_rdy && (ne0 || ne1);
    // Both waiting: serve the one not granted last; otherwise the only one waiting.
    gnt_sel   = (ne0 && ne1) ? ~last_q : ne1;
    pop0      = grant_go && !gnt_sel;
    pop1      = grant_go && gnt_sel;
    // Full is judged on the registered count, so a pop in the same cycle
    // does not make room for a write.
    push0     = wr0 && !full0;
    push1     = wr1 && !full1;
    head_data = gnt_sel ? mem1_q[rptr1_q] : mem0_q[rptr0_q];
  end

  always_ff @(posedge clk) begin
    if (rst && push0) mem0_q[wptr0_q] <= din0;
    if (rst && push1) mem1_q[wptr1_q] <= din1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      wptr0_q <= '0;
      rptr0_q <= '0;
      wptr1_q <= '0;
      rptr1_q <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      ovf_q   <= '0;
      data_q  <= '0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      fsel_q  <= 1'b0;
    end else begin
      if (push0) wptr0_q <= wptr0_q + AW'(1);
      if (push1) wptr1_q <= wptr1_q + AW'(1);
      if (pop0)  rptr0_q <= rptr0_q + AW'(1);
      if (pop1)  rptr1_q <= rptr1_q + AW'(1);
      cnt0_q <= cnt0_q + CW'(push0) - CW'(pop0);
      cnt1_q <= cnt1_q + CW'(push1) - CW'(pop1);
      if (wr0 && full0) ovf_q[0] <= 1'b1;
      if (wr1 && full1) ovf_q[1] <= 1'b1;

      // Baud select only moves between bytes, never under an in-flight one.
      if ((state_q == StIdle) && tx_rdy) fsel_q <= fsel_in;

      unique case (state_q)
        StIdle: begin
          if (grant_go) begin
            state_q <= StIssue;
            data_q  <= head_data;
            grant_q <= gnt_sel;
            last_q  <= gnt_sel;
          end
        end
        StIssue:    state_q <= StWaitBusy;
        StWaitBusy: if (!tx_rdy) state_q <= StWaitDone;
        StWaitDone: if (tx_rdy) state_q <= StIdle;
        default:    state_q <= StIdle;
      endcase
    end
  end

  assign ovf      = ovf_q;
  assign tx_fsel  = fsel_q;
  assign tx_start = (state_q == StIssue);
  assign tx_data  = data_q;
  assign busy     = (state_q != StIdle);
  assign grant_id = grant_q;

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
module tb_rs232_tx_arbiter;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, wr0, wr1, fsel_in, tx_rdy;
  logic [7:0] din0, din1;
  logic       full0, full1, tx_fsel, tx_start, busy, grant_id;
  logic [1:0] ovf;
  logic [7:0] tx_data;

  always #5 clk = ~clk;

  rs232_tx_arbiter #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr0      (wr0),
    .din0     (din0),
    .full0    (full0),
    .wr1      (wr1),
    .din1     (din1),
    .full1    (full1),
    .ovf      (ovf),
    .fsel_in  (fsel_in),
    .tx_fsel  (tx_fsel),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_rdy   (tx_rdy),
    .busy     (busy),
    .grant_id (grant_id)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: per-client byte queues, round-robin pointer, sticky drops.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] sent[$];
  logic [7:0] exp_q[$];
  logic       last_m;
  logic [1:0] ovf_m;
  bit         auto_tx;
  int         busy_left;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: capture inputs, advance, then update model and compare.
  task automatic step();
    int         pre0, pre1;
    logic       r, w0, w1, fs, g;
    logic [7:0] d0, d1;
    pre0 = q0.size();
    pre1 = q1.size();
    r  = rst;
    w0 = wr0;
    w1 = wr1;
    d0 = din0;
    d1 = din1;
    fs = fsel_in;
    @(posedge clk);
    #1;
    if (!r) begin
      q0.delete();
      q1.delete();
      last_m    = 1'b1;
      ovf_m     = 2'b00;
      busy_left = 0;
      if (auto_tx) tx_rdy = 1'b1;
    end else begin
      if (tx_start) begin
        if (pre0 > 0 && pre1 > 0) g = ~last_m;
        else                      g = (pre0 == 0);
        chk("grant_id", grant_id, g);
        chk("tx_fsel at issue", tx_fsel, fs);
        if (!g && pre0 > 0)     chk("tx_data c0", tx_data, q0.pop_front());
        else if (g && pre1 > 0) chk("tx_data c1", tx_data, q1.pop_front());
        else                    chk("tx_start with empty fifos", tx_start, 1'b0);
        last_m = g;
        sent.push_back(tx_data);
        if (auto_tx) begin
          tx_rdy    = 1'b0;
          busy_left = $urandom_range(2, 5);
        end
      end else if (auto_tx && busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) tx_rdy = 1'b1;
      end
      if (w0) begin
        if (pre0 == DEPTH) ovf_m[0] = 1'b1;
        else               q0.push_back(d0);
      end
      if (w1) begin
        if (pre1 == DEPTH) ovf_m[1] = 1'b1;
        else               q1.push_back(d1);
      end
    end
    chk("full0", full0, q0.size() == DEPTH);
    chk("full1", full1, q1.size() == DEPTH);
    chk("ovf", ovf, ovf_m);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    wr0 = 1'b0;
    wr1 = 1'b0;
    step();
    rst = 1'b1;
    chk("rst tx_start", tx_start, 1'b0);
    chk("rst tx_data", tx_data, 8'h00);
    chk("rst grant_id", grant_id, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst tx_fsel", tx_fsel, 1'b0);
    sent.delete();
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && ((q0.size() + q1.size()) > 0 || busy); i++) step();
    chk("drain model empty", q0.size() + q1.size(), 0);
    chk("drain idle", busy, 1'b0);
  endtask

  task automatic chk_sent(input string tag);
    chk(tag, sent.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < sent.size()) chk(tag, sent[i], exp_q[i]);
    end
  endtask

  initial begin
    rst = 1'b0; wr0 = 1'b0; wr1 = 1'b0; din0 = '0; din1 = '0;
    fsel_in = 1'b0; tx_rdy = 1'b1;
    auto_tx = 1'b0; busy_left = 0; last_m = 1'b1; ovf_m = 2'b00;

    // Single byte, latency and busy window.
    do_reset();
    tx_rdy = 1'b1;
    wr0 = 1'b1; din0 = 8'h41; step(); wr0 = 1'b0;
    chk("t1 no early start", tx_start, 1'b0);
    step();
    chk("t1 tx_start", tx_start, 1'b1);
    chk("t1 tx_data", tx_data, 8'h41);
    chk("t1 grant_id", grant_id, 1'b0);
    chk("t1 busy issue", busy, 1'b1);
    step();
    chk("t1 start one cycle", tx_start, 1'b0);
    chk("t1 busy wait", busy, 1'b1);
    tx_rdy = 1'b0; step();
    chk("t1 busy sending", busy, 1'b1);
    step();
    chk("t1 busy sending 2", busy, 1'b1);
    tx_rdy = 1'b1; step();
    chk("t1 idle", busy, 1'b0);

    // Round-robin with both FIFOs loaded.
    do_reset();
    tx_rdy = 1'b0;
    wr0 = 1'b1; wr1 = 1'b1; din0 = 8'hA0; din1 = 8'hB0; step();
    din0 = 8'hA1; din1 = 8'hB1; step();
    wr0 = 1'b0; wr1 = 1'b0;
    sent.delete(); auto_tx = 1'b1; tx_rdy = 1'b1;
    drain(200);
    exp_q = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
    chk_sent("t2 order");
    auto_tx = 1'b0;

    // Overflow on client 1.
    do_reset();
    tx_rdy = 1'b0; wr1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din1 = 8'(8'hC0 + i);
      step();
      if (i == 3) chk("t3 full1 after 4", full1, 1'b1);
    end
    wr1 = 1'b0;
    chk("t3 ovf", ovf, 2'b10);
    sent.delete(); auto_tx = 1'b1; tx_rdy = 1'b1;
    drain(200);
    exp_q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
    chk_sent("t3 order");
    chk("t3 ovf sticky", ovf, 2'b10);
    auto_tx = 1'b0;

    // Baud select deferred until idle with tx_rdy.
    do_reset();
    tx_rdy = 1'b1; fsel_in = 1'b0;
    wr0 = 1'b1; din0 = 8'h55; step(); wr0 = 1'b0;
    step();
    chk("t4 first start", tx_start, 1'b1);
    chk("t4 fsel slow", tx_fsel, 1'b0);
    tx_rdy = 1'b0; step(); step();
    fsel_in = 1'b1; step();
    chk("t4 hold in wait_done", tx_fsel, 1'b0);
    wr0 = 1'b1; din0 = 8'h66; step(); wr0 = 1'b0;
    chk("t4 hold in wait_done 2", tx_fsel, 1'b0);
    tx_rdy = 1'b1; step();
    chk("t4 hold on return", tx_fsel, 1'b0);
    chk("t4 idle", busy, 1'b0);
    step();
    chk("t4 fsel fast", tx_fsel, 1'b1);
    chk("t4 second start", tx_start, 1'b1);
    chk("t4 second data", tx_data, 8'h66);
    tx_rdy = 1'b0; step(); step();
    tx_rdy = 1'b1; step();
    fsel_in = 1'b0;

    // Reset during WAIT_BUSY with 3 bytes queued.
    do_reset();
    tx_rdy = 1'b1; wr0 = 1'b1;
    din0 = 8'h10; step();
    din0 = 8'h11; step();
    chk("t5 issue", tx_start, 1'b1);
    din0 = 8'h12; step();
    chk("t5 busy", busy, 1'b1);
    din0 = 8'h13; step();
    chk("t5 queued", q0.size(), 3);
    rst = 1'b0; din0 = 8'hEE; step();
    rst = 1'b1; wr0 = 1'b0;
    chk("t5 tx_start", tx_start, 1'b0);
    chk("t5 tx_data", tx_data, 8'h00);
    chk("t5 grant_id", grant_id, 1'b0);
    chk("t5 busy", busy, 1'b0);
    chk("t5 tx_fsel", tx_fsel, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t5 no start after reset", tx_start, 1'b0);
    end

    // Simultaneous write and pop at count 2.
    do_reset();
    tx_rdy = 1'b0; wr0 = 1'b1;
    din0 = 8'h20; step();
    din0 = 8'h21; step();
    tx_rdy = 1'b1; din0 = 8'h22; step();
    chk("t6 start", tx_start, 1'b1);
    chk("t6 data", tx_data, 8'h20);
    din0 = 8'h23; step();
    chk("t6 not full at 3", full0, 1'b0);
    din0 = 8'h24; step();
    wr0 = 1'b0;
    chk("t6 full0 at 4", full0, 1'b1);
    chk("t6 no drop", ovf, 2'b00);
    tx_rdy = 1'b0; step();
    sent.delete(); auto_tx = 1'b1; tx_rdy = 1'b1;
    drain(200);
    exp_q = '{8'h21, 8'h22, 8'h23, 8'h24};
    chk_sent("t6 order");

    // Random traffic against the queue model with a randomized transmitter.
    do_reset();
    auto_tx = 1'b1; tx_rdy = 1'b1;
    for (int i = 0; i < 600; i++) begin
      wr0     = ($urandom_range(0, 3) == 0);
      wr1     = ($urandom_range(0, 3) == 0);
      din0    = 8'($urandom);
      din1    = 8'($urandom);
      fsel_in = 1'($urandom_range(0, 1));
      step();
    end
    wr0 = 1'b0; wr1 = 1'b0;
    drain(500);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rs232_tx_arbiter.md
RS232_TX_ARBITER -- requirements
Module: rs232_tx_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning entries per client FIFO (power of two, 2..16).
REQ-002 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous active-low reset (rst=0 resets on the next clk edge).
REQ-004 The block SHALL have port wr0  input  1  client 0 write strobe, one byte per high cycle.
REQ-005 The block SHALL have port din0  input  8  client 0 byte, sampled when wr0=1.
REQ-006 The block SHALL have port full0  output  1  client 0 FIFO holds DEPTH bytes.
REQ-007 The block SHALL have ports wr1, din1 and full1 with the same directions, widths and meanings for client 1.
REQ-008 The block SHALL have port ovf  output  2  sticky drop flags; bit i set when client i writes while full.
REQ-009 The block SHALL have port fsel_in  input  1  requested baud select (1=fast, 0=slow).
REQ-010 The block SHALL have port tx_fsel  output  1  baud select driven to the transmitter.
REQ-011 The block SHALL have port tx_start  output  1  one-cycle send request to the transmitter.
REQ-012 The block SHALL have port tx_data  output  8  byte to send, valid while tx_start=1.
REQ-013 The block SHALL have port tx_rdy  input  1  transmitter idle (1) / sending (0).
REQ-014 The block SHALL have port busy  output  1  high in any FSM state other than IDLE.
REQ-015 The block SHALL have port grant_id  output  1  client whose byte is issued or in flight.

Function
REQ-016 Each client SHALL own a DEPTH-entry FIFO with a registered occupancy count of width log2(DEPTH)+1, and full_i SHALL equal (count_i == DEPTH).
REQ-017 A write with full_i=1 SHALL be dropped and SHALL set ovf[i], even if the same FIFO is popped that cycle.
REQ-018 A write and a pop on the same non-full FIFO in one cycle SHALL both occur, leaving count unchanged.
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
REQ-020 IDLE -> ISSUE SHALL occur when tx_rdy=1 and at least one count is nonzero; that edge SHALL pop the granted FIFO, load tx_data and set grant_id.
REQ-021 If only one FIFO is nonempty, it SHALL be granted; if both are, the client not granted last SHALL be granted (round-robin; last-grant register resets to 1, so client 0 wins first).
REQ-022 tx_start SHALL equal (state == ISSUE), so it is high for exactly one cycle per byte.
REQ-023 ISSUE -> WAIT_BUSY SHALL be unconditional.
REQ-024 WAIT_BUSY -> WAIT_DONE SHALL occur when tx_rdy=0.
REQ-025 WAIT_DONE -> IDLE SHALL occur when tx_rdy=1.
REQ-026 tx_data and grant_id SHALL hold their values from ISSUE until the next grant.
REQ-027 Latency SHALL be: a byte written at edge E into an empty FIFO, with the FSM in IDLE and tx_rdy=1, gives tx_start=1 in the cycle after edge E+1.
REQ-028 tx_fsel SHALL load fsel_in only on edges where state=IDLE and tx_rdy=1; changes of fsel_in at other times SHALL be deferred and never alter an in-flight byte.
REQ-029 Bytes from one client SHALL be transmitted in write order, with no loss except for REQ-017 drops.

Reset
REQ-030 On an edge with rst=0, the block SHALL set state=IDLE, both counts and pointers=0, ovf=00, tx_start=0, tx_data=0, grant_id=0, last-grant=1, tx_fsel=0, busy=0 and full0=full1=0.
REQ-031 Reset asserted mid-operation SHALL flush both FIFOs and drop any in-flight grant without a further tx_start; the transmitter is reset by the same rst.
REQ-032 Writes on a cycle with rst=0 SHALL be ignored.

Verification
REQ-033 The bench SHALL cover this case: wr0 with 0x41 in idle, tx_rdy=1 -> tx_start high exactly 2 cycles later, tx_data=0x41, grant_id=0, busy=1 until tx_rdy returns to 1.
REQ-034 The bench SHALL cover this case: both FIFOs preloaded with 0xA0,0xA1 and 0xB0,0xB1 -> issue order A0,B0,A1,B1.
REQ-035 The bench SHALL cover this case: DEPTH+1 writes to client 1 while the transmitter is held busy -> full1=1 after the 4th write, the 5th is dropped, ovf=10, and 4 bytes are later sent in order.
REQ-036 The bench SHALL cover this case: fsel_in toggled 0->1 during WAIT_DONE -> tx_fsel stays 0 until the FSM is IDLE with tx_rdy=1, then becomes 1 before the next tx_start.
REQ-037 The bench SHALL cover this case: rst=0 for one cycle during WAIT_BUSY with 3 bytes queued -> all outputs take their REQ-030 values and no tx_start occurs afterwards without new writes.
REQ-038 The bench SHALL cover this case: simultaneous wr0 and pop of FIFO 0 at count=2 -> count stays 2 and byte order is preserved.
